mul_div_unit: RTL

Multi-cycle HI/LO functional unit beside the single-cycle ALU in the execute stage. It executes MULT, MULTU, DIV and DIVU iteratively, and MTHI/MTLO in a single cycle, and owns the architectural HI/LO registers. It consumes the same 32-bit operand buses as the ALU. A start/busy/done handshake lets the control path stall on MFHI/MFLO or on a new HI/LO op while an operation is in flight.

---
 rtl/mul_div_unit_pkg.sv | 25 ++
 rtl/mul_div_unit_if.sv | 18 +
 rtl/mul_div_unit_step.sv | 32 +++
 rtl/mul_div_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and a magnitude helper used when latching signed operands.
package mips_pkg;

  localparam int MD_W = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } md_state_t;

  // 0x80000000 maps to itself, which the unsigned datapath reads as 2^31.
  function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] v);
    return v[MD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute-stage control path and the HI/LO unit.
interface md_if;
  import mips_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [MD_W-1:0] a;
  logic [MD_W-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [MD_W-1:0] hi;
  logic [MD_W-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);

endinterface

// File: rtl/mul_div_unit_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
// acc is the upper half (partial product / remainder), part the lower half (multiplier / quotient).
module md_step #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] opnd,
  input  logic [W-1:0] part,
  output logic [W-1:0] acc_nxt,
  output logic [W-1:0] part_nxt
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic       ge;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (part[0] ? opnd : {W{1'b0}})};
    shifted = {acc, part[W-1]};
    ge      = (shifted >= {1'b0, opnd});
    if (is_div) begin
      // When ge holds the true difference is below 2^W, so a W-bit subtract is exact.
      acc_nxt  = ge ? (shifted[W-1:0] - opnd) : shifted[W-1:0];
      part_nxt = {part[W-2:0], ge};
    end else begin
      acc_nxt  = sum[W:1];
      part_nxt = {sum[0], part[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO unit: MULT/MULTU/DIV/DIVU in 33 busy cycles, MTHI/MTLO in one.
// Owns the architectural HI/LO registers; flush aborts without touching them.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic clk,
  input logic reset_n,
  md_if.slave md
);

  localparam int               CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   acc_step, part_step;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  md_step #(.W(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .part     (part_q),
    .acc_nxt  (acc_step),
    .part_nxt (part_step)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    part_d   = part_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;

    is_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
    a_mag     = is_signed ? md_abs(md.a) : md.a;
    b_mag     = is_signed ? md_abs(md.b) : md.b;
    prod_fix  = neg_wide_if(neg_lo_q, {acc_q, part_q});

    case (state_q)
      IDLE: begin
        if (md.start && !md.flush) begin
          case (md.op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = RUN;
              count_d  = '0;
              busy_d   = 1'b1;
              is_div_d = md.op[1];
              acc_d    = '0;
              part_d   = md.op[1] ? a_mag : b_mag;
              opnd_d   = md.op[1] ? b_mag : a_mag;
              neg_lo_d = is_signed && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
              neg_hi_d = is_signed && md.a[WIDTH-1];
              dz_d     = (md.b == '0);
            end
            MD_MTHI: begin
              hi_d   = md.a;
              done_d = 1'b1;
            end
            MD_MTLO: begin
              lo_d   = md.a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d   = acc_step;
        part_d  = part_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FINISH;
      end
      FINISH: begin
        // Divide by zero leaves |a| in acc, so the remainder fix-up restores the raw a.
        if (is_div_q) begin
          lo_d = dz_q ? '1 : neg_if(neg_lo_q, part_q);
          hi_d = neg_if(neg_hi_q, acc_q);
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (md.flush && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      count_d = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath registers are reloaded on every accepted op, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    part_q   <= part_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    dz_q     <= dz_d;
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
